// File: rtl/seg_scan_decoder_if.sv
// Scan-bus interface between a seven-segment display driver and its readback decoder.
// The decoder side (slave) samples an/seg and reports the reconstructed digits.
interface seg_scan_decoder_if;
  logic [3:0] an;
  logic [7:0] seg;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] digit_valid;
  logic       frame_done;
  logic       err_multi_an;
  logic       stale;

  modport master (
    output an, seg,
    input  digit0, digit1, digit2, digit3, digit_valid, frame_done, err_multi_an, stale
  );

  modport slave (
    input  an, seg,
    output digit0, digit1, digit2, digit3, digit_valid, frame_done, err_multi_an, stale
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Readback decoder for a multiplexed 4-digit seven-segment scan bus: captures each
// stable scan slot, flags multi-anode slots, reports complete frames and staleness.
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT       = 4000
) (
  input  logic               clk,
  input  logic               rst,
  seg_scan_decoder_if.slave  bus
);

  localparam logic [7:0]  SETTLE = 8'(SETTLE_CYCLES);
  localparam logic [20:0] TMO    = 21'(TIMEOUT);

  logic [11:0] sync1;
  logic [11:0] a_s;
  logic [11:0] a_q;
  logic [7:0]  cnt;
  logic [20:0] tcnt;
  logic [3:0]  seen;
  logic [3:0]  digit_q [4];
  logic [3:0]  valid_q;
  logic        frame_done_q;
  logic        err_q;
  logic        stale_q;

  logic        capture;
  logic [3:0]  value;
  logic [3:0]  hit;
  logic        multi;
  logic        frame_edge;
  logic        timeout_hit;

  // Capture fires exactly once, on the edge the stability counter reaches SETTLE.
  always_comb begin
    capture     = (a_s == a_q) && (cnt == SETTLE - 8'd1);
    frame_edge  = (seen == 4'hF);
    timeout_hit = !frame_edge && (tcnt == TMO - 21'd1);
    hit         = 4'h0;
    multi       = 1'b0;
    if (capture) begin
      if ($onehot(~a_s[11:8]))
        hit = ~a_s[11:8];
      else if (a_s[11:8] != 4'hF)
        multi = 1'b1;
    end
  end

  // Active-low segment patterns; dp (bit 7) plays no part in the value.
  always_comb begin
    case (a_s[6:0])
      7'h40:   value = 4'd0;
      7'h79:   value = 4'd1;
      7'h24:   value = 4'd2;
      7'h30:   value = 4'd3;
      7'h19:   value = 4'd4;
      7'h12:   value = 4'd5;
      7'h02:   value = 4'd6;
      7'h78:   value = 4'd7;
      7'h00:   value = 4'd8;
      7'h10:   value = 4'd9;
      7'h7F:   value = 4'd10;
      default: value = 4'd15;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1        <= 12'hFFF;
      a_s          <= 12'hFFF;
      a_q          <= 12'hFFF;
      cnt          <= 8'd0;
      tcnt         <= 21'd0;
      seen         <= 4'h0;
      valid_q      <= 4'h0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      stale_q      <= 1'b0;
      for (int n = 0; n < 4; n++) digit_q[n] <= 4'hF;
    end else begin
      sync1 <= {bus.an, bus.seg};
      a_s   <= sync1;
      a_q   <= a_s;

      if (a_s != a_q)
        cnt <= 8'd0;
      else if (cnt < SETTLE)
        cnt <= cnt + 8'd1;

      for (int n = 0; n < 4; n++)
        if (hit[n]) digit_q[n] <= value;

      // A completed mask is reported one edge later and cleared on that same edge.
      seen         <= (frame_edge ? 4'h0 : seen) | hit;
      frame_done_q <= frame_edge;
      err_q        <= multi;

      if (frame_edge)
        tcnt <= 21'd0;
      else if (tcnt < TMO)
        tcnt <= tcnt + 21'd1;

      if (frame_edge)
        stale_q <= 1'b0;
      else if (timeout_hit)
        stale_q <= 1'b1;

      valid_q <= timeout_hit ? 4'h0 : (valid_q | hit);
    end
  end

  assign bus.digit0       = digit_q[0];
  assign bus.digit1       = digit_q[1];
  assign bus.digit2       = digit_q[2];
  assign bus.digit3       = digit_q[3];
  assign bus.digit_valid  = valid_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.err_multi_an = err_q;
  assign bus.stale        = stale_q;

endmodule
